// File: rtl/piso_register_unload.sv
// piso_register_unload: parallel-in, serial-out unload register.
// Captures an n-bit word on an accepted load (ready=1) and emits it one bit
// per clock with so_valid, then pulses done for one cycle and returns to IDLE.
// Optional build macro: PISO_LSB_FIRST_EN -- emit the word LSB-first instead
// of the default MSB-first order; timing is identical in both builds.
module piso_register_unload #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] I,
    input  logic         load,
    output logic         ready,
    output logic         so,
    output logic         so_valid,
    output logic         done
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;

`ifdef PISO_LSB_FIRST_EN
    localparam int OUT_BIT = 0;
`else
    localparam int OUT_BIT = n - 1;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [n-1:0]    qreg;
    logic [CW-1:0]   cnt;

    // Control FSM: capture the word, shift it toward the output end, register done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            qreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        qreg  <= I;
                        cnt   <= CW'(n - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef PISO_LSB_FIRST_EN
                    qreg <= qreg >> 1;
`else
                    qreg <= qreg << 1;
`endif
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Status and serial data decoded directly from state/qreg (no added latency).
    always_comb begin
        ready    = (state == IDLE);
        so_valid = (state == SHIFT);
        so       = (state == SHIFT) & qreg[OUT_BIT];
    end

endmodule

// File: tb/tb_piso_register_unload.sv
// tb_piso_register_unload: scoreboard bench for piso_register_unload.
// Expected bits are queued when a word is driven and popped as so_valid bits
// appear. Honours PISO_LSB_FIRST_EN for the expected bit order.
module tb_piso_register_unload;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] I;
    logic       load;
    logic       ready, so, so_valid, done;

    logic [0:0] I1;
    logic       load1;
    logic       ready1, so1, so_valid1, done1;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    bit eb;

    piso_register_unload #(.n(4)) u_dut (
        .clk(clk), .rst(rst), .I(I), .load(load),
        .ready(ready), .so(so), .so_valid(so_valid), .done(done)
    );

    piso_register_unload #(.n(1)) u_dut1 (
        .clk(clk), .rst(rst), .I(I1), .load(load1),
        .ready(ready1), .so(so1), .so_valid(so_valid1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic void push_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
`ifdef PISO_LSB_FIRST_EN
            exp_q.push_back(w[i]);
`else
            exp_q.push_back(w[3-i]);
`endif
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; I = '0; load1 = 1'b0; I1 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, so, so_valid, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_n4: got rdy/so/vld/done=%b required 1000", {ready, so, so_valid, done});
        end
        checks++;
        if ({ready1, so1, so_valid1, done1} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_n1: got rdy/so/vld/done=%b required 1000", {ready1, so1, so_valid1, done1});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_word(input logic [3:0] w, input string name);
        I = w; load = 1'b1; push_word(w);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c <= 4) begin
                checks++;
                if (so_valid !== 1'b1 || ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_busy c%0d: got vld=%b rdy=%b required vld=1 rdy=0", name, c, so_valid, ready);
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s_queue c%0d: got empty scoreboard required a pending bit", name, c);
                end else begin
                    eb = exp_q.pop_front();
                    checks++;
                    if (so !== eb) begin
                        errors++;
                        $display("FAIL %s_bit c%0d: got so=%b required %b", name, c, so, eb);
                    end
                end
            end else begin
                checks++;
                if ({ready, so, so_valid} !== 3'b100) begin
                    errors++;
                    $display("FAIL %s_idle c%0d: got rdy/so/vld=%b required 100", name, c, {ready, so, so_valid});
                end
            end
            checks++;
            if (done !== (c == 5)) begin
                errors++;
                $display("FAIL %s_done c%0d: got done=%b required %b", name, c, done, (c == 5));
            end
        end
    endtask

    task automatic test_load_ignored();
        I = 4'b1100; load = 1'b1; push_word(4'b1100);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ignore_queue c%0d: got empty scoreboard required a pending bit", c);
                end else begin
                    eb = exp_q.pop_front();
                    checks++;
                    if (so_valid !== 1'b1 || so !== eb) begin
                        errors++;
                        $display("FAIL ignore_bit c%0d: got vld=%b so=%b required vld=1 so=%b", c, so_valid, so, eb);
                    end
                end
            end else begin
                checks++;
                if ({ready, so_valid} !== 2'b10) begin
                    errors++;
                    $display("FAIL ignore_idle c%0d: got rdy/vld=%b required 10", c, {ready, so_valid});
                end
            end
            checks++;
            if (done !== (c == 5)) begin
                errors++;
                $display("FAIL ignore_done c%0d: got done=%b required %b", c, done, (c == 5));
            end
            // Second word strobed only across the edge ending SHIFT cycle 2.
            if (c == 2) begin load = 1'b1; I = 4'b0011; end
            else load = 1'b0;
        end
    endtask

    task automatic test_reset_mid_shift();
        I = 4'b1111; load = 1'b1; push_word(4'b1111);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c <= 2) begin
                eb = exp_q.pop_front();
                checks++;
                if (so_valid !== 1'b1 || so !== eb) begin
                    errors++;
                    $display("FAIL rstmid_bit c%0d: got vld=%b so=%b required vld=1 so=%b", c, so_valid, so, eb);
                end
            end else begin
                checks++;
                if ({ready, so_valid, done} !== 3'b100) begin
                    errors++;
                    $display("FAIL rstmid_abort c%0d: got rdy/vld/done=%b required 100", c, {ready, so_valid, done});
                end
            end
            if (c == 2) rst = 1'b1;
            else rst = 1'b0;
        end
        exp_q.delete();
        test_single_word(4'b0101, "after_rst");
    endtask

    task automatic test_back_to_back();
        I = 4'b1001; load = 1'b1;
        push_word(4'b1001);
        push_word(4'b0110);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 5 || c >= 10) begin
                checks++;
                if ({ready, so_valid} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_gap c%0d: got rdy/vld=%b required 10", c, {ready, so_valid});
                end
            end else begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b2b_queue c%0d: got empty scoreboard required a pending bit", c);
                end else begin
                    eb = exp_q.pop_front();
                    checks++;
                    if (so_valid !== 1'b1 || ready !== 1'b0 || so !== eb) begin
                        errors++;
                        $display("FAIL b2b_bit c%0d: got vld=%b rdy=%b so=%b required vld=1 rdy=0 so=%b",
                                 c, so_valid, ready, so, eb);
                    end
                end
            end
            checks++;
            if (done !== (c == 5 || c == 10)) begin
                errors++;
                $display("FAIL b2b_done c%0d: got done=%b required %b", c, done, (c == 5 || c == 10));
            end
            if (c == 1) I = 4'b0110;
            if (c == 9) load = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d bits left required 0", exp_q.size());
        end
    endtask

    task automatic test_n1();
        I1 = 1'b1; load1 = 1'b1;
        exp_q.push_back(1'b1);
        @(negedge clk);
        load1 = 1'b0; I1 = 1'b0;
        eb = exp_q.pop_front();
        checks++;
        if ({ready1, so_valid1, so1, done1} !== {1'b0, 1'b1, eb, 1'b0}) begin
            errors++;
            $display("FAIL n1_bit: got rdy/vld/so/done=%b required 01%b0", {ready1, so_valid1, so1, done1}, eb);
        end
        @(negedge clk);
        checks++;
        if ({ready1, so_valid1, so1, done1} !== 4'b1001) begin
            errors++;
            $display("FAIL n1_done: got rdy/vld/so/done=%b required 1001", {ready1, so_valid1, so1, done1});
        end
        @(negedge clk);
        checks++;
        if ({ready1, so_valid1, done1} !== 3'b100) begin
            errors++;
            $display("FAIL n1_idle: got rdy/vld/done=%b required 100", {ready1, so_valid1, done1});
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single_word(4'b1011, "basic");
        test_load_ignored();
        test_reset_mid_shift();
        test_back_to_back();
        test_n1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
